// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared funct3 codes, FSM state and byte-enable types for the data-memory access unit
package dm_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef logic [3:0] be_t;

endpackage

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - byte-lane steering for stores and extraction/extension for loads
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] rdata_i,
  output be_t         be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_ext_o,
  output logic        aligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Unsigned variants differ only in funct3[2]; any unlisted code behaves as a word access
  always_comb begin
    be_o      = 4'b1111;
    wdata_o   = rs2_data_i;
    ld_ext_o  = rdata_i;
    aligned_o = (addr_lo_i == 2'b00);
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o      = 4'b0001 << addr_lo_i;
        wdata_o   = {4{rs2_data_i[7:0]}};
        ld_ext_o  = {{24{byte_sel[7] & ~funct3_i[2]}}, byte_sel};
        aligned_o = 1'b1;
      end
      F3_H, F3_HU: begin
        be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o   = {2{rs2_data_i[15:0]}};
        ld_ext_o  = {{16{half_sel[15] & ~funct3_i[2]}}, half_sel};
        aligned_o = ~addr_lo_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - MEM-stage data-memory access FSM with req/gnt/rvalid SRAM handshake and timeout
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [31:0]       rs2_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              pipe_stall,
  output logic              misalign,
  output logic              bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  be_t               be_q;
  logic [31:0]       wdata_q, rdata_q;
  logic [2:0]        f3_q;
  logic              we_q, bus_err_q;

  logic              in_idle, acc, start, busy, timed_out;
  logic [2:0]        la_f3;
  logic [1:0]        la_addr;
  be_t               la_be;
  logic [31:0]       la_wdata, la_ld_ext;
  logic              la_aligned;

  assign in_idle = (state_q == IDLE);
  assign acc     = dm_read | dm_write;

  // Idle decodes the live instruction; afterwards extraction uses the captured access
  assign la_f3   = in_idle ? funct3 : f3_q;
  assign la_addr = in_idle ? alu_addr[1:0] : addr_q[1:0];

  dm_lane_align u_lane_align (
    .funct3_i   (la_f3),
    .addr_lo_i  (la_addr),
    .rs2_data_i (rs2_data),
    .rdata_i    (mem_rdata),
    .be_o       (la_be),
    .wdata_o    (la_wdata),
    .ld_ext_o   (la_ld_ext),
    .aligned_o  (la_aligned)
  );

  assign start     = in_idle & acc & la_aligned;
  assign busy      = (state_q == REQ) | (state_q == WAIT);
  assign cnt_d     = busy ? cnt_q + 8'd1 : 8'd0;
  assign timed_out = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= '0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      f3_q      <= 3'd0;
      we_q      <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= alu_addr;
            be_q    <= dm_write ? la_be : 4'b1111;
            wdata_q <= la_wdata;
            f3_q    <= funct3;
            we_q    <= dm_write;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state_q <= we_q ? DONE : WAIT;
          end else if (timed_out) begin
            rdata_q   <= 32'd0;
            bus_err_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata_q <= la_ld_ext;
            state_q <= DONE;
          end else if (timed_out) begin
            rdata_q   <= 32'd0;
            bus_err_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign ld_data   = rdata_q;
  assign ld_valid  = (state_q == DONE) & ~we_q;
  assign bus_err   = bus_err_q;

  // Gated by rst_n so a held request during reset cannot raise stall or misalign
  assign pipe_stall = rst_n & (busy | start);
  assign misalign   = rst_n & in_idle & acc & ~la_aligned;

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - randomized self-checking bench for dm_access_unit against a behavioural model
module tb_dm_access_unit;

  localparam int TO = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dm_read = 1'b0, dm_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] alu_addr = 32'd0, rs2_data = 32'd0;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] ld_data;
  logic        ld_valid, pipe_stall, misalign, bus_err;

  int total = 0;
  int bad = 0;
  logic [31:0] last_ld = 32'd0;

  always #5 clk = ~clk;

  dm_access_unit #(.TIMEOUT_CYC(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .dm_read(dm_read), .dm_write(dm_write), .funct3(funct3),
    .alu_addr(alu_addr), .rs2_data(rs2_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ld_data(ld_data), .ld_valid(ld_valid),
    .pipe_stall(pipe_stall), .misalign(misalign), .bus_err(bus_err)
  );

  function automatic int sz(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (!wr) return 4'hF;
    if (sz(f3) == 1) return 4'(1 << off);
    if (sz(f3) == 2) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    if (sz(f3) == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
    if (sz(f3) == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] ref_ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] w;
    logic        signed_ld;
    w = rdata >> (8 * (addr % 4));
    signed_ld = (f3 == 3'b000 || f3 == 3'b001);
    if (sz(f3) == 1) begin
      w = w & 32'hFF;
      if (signed_ld && w >= 128) w = w + 32'hFFFF_FF00;
    end else if (sz(f3) == 2) begin
      w = w & 32'hFFFF;
      if (signed_ld && w >= 32768) w = w + 32'hFFFF_0000;
    end else begin
      w = rdata;
    end
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [31:0] rdata, input int gdly, input int rdly);
    logic al, ld;
    logic [31:0] exp_ld;
    ld = !wr;
    al = ((addr % sz(f3)) == 0);
    tick;
    dm_read = rd; dm_write = wr; funct3 = f3; alu_addr = addr; rs2_data = rs2;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    total++;
    if ({mem_req, pipe_stall, misalign, ld_valid} !== {1'b0, al, !al, 1'b0}) begin
      bad++;
      $display("FAIL issue addr=%h f3=%0d req/stall/mis/ldv got=%b%b%b%b exp=0%b%b0",
               addr, f3, mem_req, pipe_stall, misalign, ld_valid, al, !al);
    end
    if (!al) return;
    for (int c = 0; c <= gdly; c++) begin
      tick;
      mem_gnt = (c == gdly); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      #1;
      total++;
      if ({mem_req, mem_we, mem_be, mem_addr, pipe_stall, bus_err} !==
          {1'b1, wr, ref_be(wr, f3, addr), addr & ~32'h3, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL req addr=%h f3=%0d got req=%b we=%b be=%b maddr=%h stall=%b err=%b exp we=%b be=%b maddr=%h",
                 addr, f3, mem_req, mem_we, mem_be, mem_addr, pipe_stall, bus_err,
                 wr, ref_be(wr, f3, addr), addr & ~32'h3);
      end
      if (wr) begin
        total++;
        if (mem_wdata !== ref_wdata(f3, rs2)) begin
          bad++;
          $display("FAIL wdata addr=%h f3=%0d got=%h exp=%h", addr, f3, mem_wdata, ref_wdata(f3, rs2));
        end
      end
    end
    if (ld) begin
      for (int c = 0; c <= rdly; c++) begin
        tick;
        mem_gnt = 1'b0; mem_rvalid = (c == rdly); mem_rdata = (c == rdly) ? rdata : $urandom;
        #1;
        total++;
        if ({mem_req, pipe_stall, ld_valid} !== 3'b010) begin
          bad++;
          $display("FAIL wait addr=%h req/stall/ldv got=%b%b%b exp=010", addr, mem_req, pipe_stall, ld_valid);
        end
      end
    end
    tick;
    mem_gnt = 1'b0; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    #1;
    exp_ld = ld ? ref_ld(f3, addr, rdata) : last_ld;
    total++;
    if ({mem_req, pipe_stall, ld_valid, bus_err, ld_data} !== {1'b0, 1'b0, ld, 1'b0, exp_ld}) begin
      bad++;
      $display("FAIL done addr=%h f3=%0d got req/stall/ldv/err=%b%b%b%b ld=%h exp=00%b0 ld=%h",
               addr, f3, mem_req, pipe_stall, ld_valid, bus_err, ld_data, ld, exp_ld);
    end
    last_ld = exp_ld;
  endtask

  task automatic idle_cycle;
    tick;
    dm_read = 1'b0; dm_write = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    total++;
    if ({mem_req, pipe_stall, misalign, ld_valid, bus_err, ld_data} !== {5'b0, last_ld}) begin
      bad++;
      $display("FAIL idle req/stall/mis/ldv/err=%b%b%b%b%b ld=%h exp 00000 ld=%h",
               mem_req, pipe_stall, misalign, ld_valid, bus_err, ld_data, last_ld);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; dm_read = 1'b1; funct3 = 3'b010; alu_addr = 32'h100;
    #12;
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, ld_data, ld_valid, pipe_stall, misalign, bus_err} !== '0) begin
      bad++;
      $display("FAIL reset req=%b we=%b be=%b addr=%h wd=%h ld=%h ldv=%b stall=%b mis=%b err=%b exp all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, ld_data, ld_valid, pipe_stall, misalign, bus_err);
    end
    tick;
    rst_n = 1'b1; dm_read = 1'b0;
    idle_cycle;
  endtask

  task automatic test_plan_cases;
    run_access(1'b0, 1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0);
    idle_cycle;
    run_access(1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 32'h0000_80FF, 0, 2);
    total++;
    if (ld_data !== 32'hFFFF_FF80) begin
      bad++;
      $display("FAIL lb_const got=%h exp=ffffff80", ld_data);
    end
    run_access(1'b1, 1'b0, 3'b100, 32'h2001, 32'h0, 32'h0000_80FF, 0, 2);
    run_access(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 32'h7FFF_1234, 1, 0);
    idle_cycle;
  endtask

  task automatic test_misalign;
    run_access(1'b1, 1'b0, 3'b010, 32'h2001, 32'h0, 32'h0, 0, 0);
    run_access(1'b0, 1'b1, 3'b001, 32'h2003, 32'h1234, 32'h0, 0, 0);
    for (int c = 0; c < 2; c++) idle_cycle;
  endtask

  task automatic test_timeout(input bit in_wait);
    run_access(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 32'h8000_0001, 0, 0);
    tick;
    dm_read = 1'b1; dm_write = 1'b0; funct3 = 3'b010; alu_addr = 32'h5004; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    for (int c = 0; c < TO; c++) begin
      tick;
      mem_gnt = (in_wait && c == 0); mem_rvalid = 1'b0;
      #1;
      total++;
      if ({mem_req, bus_err, pipe_stall} !== {(!in_wait || c == 0), 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL to_busy wait=%0d c=%0d req/err/stall got=%b%b%b", in_wait, c, mem_req, bus_err, pipe_stall);
      end
    end
    tick;
    mem_gnt = 1'b0;
    #1;
    total++;
    if ({mem_req, bus_err, pipe_stall, ld_data} !== {3'b010, 32'h0}) begin
      bad++;
      $display("FAIL to_abort wait=%0d got req/err/stall=%b%b%b ld=%h exp 010 ld=0",
               in_wait, mem_req, bus_err, pipe_stall, ld_data);
    end
    last_ld = 32'h0;
    tick;
    dm_read = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    total++;
    if ({mem_req, bus_err, pipe_stall, ld_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL to_late got req/err/stall/ldv=%b%b%b%b exp 0000", mem_req, bus_err, pipe_stall, ld_valid);
    end
    idle_cycle;
  endtask

  task automatic test_reset_mid(input bit in_wait);
    run_access(1'b1, 1'b0, 3'b010, 32'h6000, 32'h0, 32'h1357_9BDF, 0, 0);
    tick;
    dm_read = 1'b1; dm_write = 1'b0; funct3 = 3'b010; alu_addr = 32'h6004; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    tick;
    mem_gnt = in_wait;
    #1;
    if (in_wait) begin
      tick;
      mem_gnt = 1'b0;
      #1;
    end
    total++;
    if ({mem_req, pipe_stall} !== {!in_wait, 1'b1}) begin
      bad++;
      $display("FAIL pre_rst wait=%0d req/stall got=%b%b exp=%b1", in_wait, mem_req, pipe_stall, !in_wait);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_req, pipe_stall, ld_valid, misalign, bus_err, mem_be, ld_data} !== {5'b0, 4'h0, 32'h0}) begin
      bad++;
      $display("FAIL mid_rst wait=%0d req/stall/ldv/mis/err=%b%b%b%b%b be=%b ld=%h exp all 0",
               in_wait, mem_req, pipe_stall, ld_valid, misalign, bus_err, mem_be, ld_data);
    end
    tick;
    rst_n = 1'b1; dm_read = 1'b0;
    last_ld = 32'h0;
    run_access(1'b0, 1'b1, 3'b010, 32'h3000, $urandom, 32'h0, 0, 0);
    idle_cycle;
  endtask

  task automatic test_back_to_back;
    run_access(1'b1, 1'b1, 3'b010, 32'h4000, 32'hCAFE_F00D, 32'h0, 0, 0);
    run_access(1'b1, 1'b0, 3'b010, 32'h4004, 32'h0, $urandom, 0, 0);
    run_access(1'b0, 1'b1, 3'b010, 32'h4008, $urandom, 32'h0, 0, 0);
    run_access(1'b1, 1'b0, 3'b010, 32'h400C, 32'h0, $urandom, 0, 0);
    idle_cycle;
  endtask

  task automatic test_random;
    int kind;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      run_access(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle_cycle;
    end
    idle_cycle;
  endtask

  initial begin
    test_reset;
    test_plan_cases;
    test_misalign;
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
